// File: rtl/lsu_wb_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// fault causes and the store-lane helpers used by the top level.
package lsu_wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_LD_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_ST_MIS  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WB     = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  // Loads reject 011/110/111; stores only know SB/SH/SW.
  function automatic logic funct3_illegal(input logic load, input logic [2:0] f3);
    logic ill;
    if (load) ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else      ill = f3[2] || (f3[1:0] == 2'b11);
    return ill;
  endfunction

  // Size code is funct3[1:0]; bytes never misalign.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SIZE_B:  strb = 4'b0001 << off;
      SIZE_H:  strb = off[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the store operand across lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rs2);
    logic [31:0] d;
    case (size)
      SIZE_B:  d = {4{rs2[7:0]}};
      SIZE_H:  d = {2{rs2[15:0]}};
      default: d = rs2;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// Word-addressed data-memory handshake between the LSU (master) and memory (slave).
interface lsu_wb_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/lsu_wb_load_align.sv
// Combinational load extractor: picks the byte/halfword lane from a word
// and sign- or zero-extends it according to funct3.
module load_align
  import lsu_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension.
  always_comb begin
    case (addr)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LW:   value = rdata;
      F3_LBU:  value = {24'h0, byte_sel};
      F3_LHU:  value = {16'h0, half_sel};
      default: value = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit and register-file write-back source.
//   state  | meaning
//   IDLE   | ready for a new request from execute
//   ACCESS | memory request outstanding, waiting for dmem_ack
//   WB     | one-cycle register-file write of the aligned load data
//   FAULT  | one-cycle misaligned / illegal-width exception pulse
// Every output is a decode of registered state and request fields only, so
// nothing on req_* reaches the memory or register-file ports combinationally.
module lsu_wb
  import lsu_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  lsu_wb_if.master    dmem,
  output logic        rf_we,
  output logic [4:0]  rf_w_addr,
  output logic [31:0] rf_w_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  state_t      state_q, state_d;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [1:0]  cause_q;
  logic [31:0] ldata_q;

  logic        accept;
  logic        illegal;
  logic        mis;
  logic [1:0]  cause_d;
  logic [31:0] aligned;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_wdata_o;

  assign accept = req_valid && (state_q == ST_IDLE);

  load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (funct3_q),
    .value  (aligned)
  );

  // Classify the incoming request; illegal width wins over misalignment.
  always_comb begin
    illegal = funct3_illegal(req_load, req_funct3);
    mis     = misaligned(req_funct3[1:0], req_addr[1:0]);
    if (illegal)       cause_d = CAUSE_ILLEGAL;
    else if (req_load) cause_d = CAUSE_LD_MIS;
    else               cause_d = CAUSE_ST_MIS;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (illegal || mis) ? ST_FAULT : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (dmem.dmem_ack) state_d = load_q ? ST_WB : ST_IDLE;
      end
      ST_WB:    state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request fields are sampled only on accept; upstream may change them otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q   <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rd_q     <= 5'd0;
      cause_q  <= CAUSE_NONE;
    end else if (accept) begin
      load_q   <= req_load;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rd_q     <= req_rd;
      cause_q  <= cause_d;
    end
  end

  // Capture the aligned load result on the acknowledging cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              ldata_q <= 32'h0;
    else if (state_q == ST_ACCESS && dmem.dmem_ack && load_q) ldata_q <= aligned;
  end

  // Output decode from registered state; ports idle at zero outside their state.
  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_wstrb_o = 4'b0000;
    dmem_wdata_o = 32'h0;
    rf_we        = 1'b0;
    rf_w_addr    = 5'd0;
    rf_w_data    = 32'h0;
    fault        = 1'b0;
    fault_cause  = CAUSE_NONE;
    fault_addr   = 32'h0;
    case (state_q)
      ST_ACCESS: begin
        dmem_req_o  = 1'b1;
        dmem_we_o   = !load_q;
        dmem_addr_o = {addr_q[31:2], 2'b00};
        if (!load_q) begin
          dmem_wstrb_o = store_strb(funct3_q[1:0], addr_q[1:0]);
          dmem_wdata_o = store_data(funct3_q[1:0], wdata_q);
        end
      end
      ST_WB: begin
        rf_we     = (rd_q != 5'd0);
        rf_w_addr = rd_q;
        rf_w_data = ldata_q;
      end
      ST_FAULT: begin
        fault       = 1'b1;
        fault_cause = cause_q;
        fault_addr  = addr_q;
      end
      default: ;
    endcase
  end

  assign dmem.dmem_req   = dmem_req_o;
  assign dmem.dmem_we    = dmem_we_o;
  assign dmem.dmem_addr  = dmem_addr_o;
  assign dmem.dmem_wstrb = dmem_wstrb_o;
  assign dmem.dmem_wdata = dmem_wdata_o;

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store unit and write-back source for the RV32I 3-stage pipeline. It accepts one memory operation from the execute stage, drives a word-addressed data-memory handshake, and aligns and sign- or zero-extends load data. It then issues a single-cycle write into the register file write port (`we`/`w_addr`/`w_data`). Misaligned and illegal-width accesses never reach memory and are reported as a fault pulse for the Zicsr trap logic.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage presents an operation.
- `req_ready` out 1: high only in IDLE; transfer on `req_valid & req_ready`.
- `req_load` in 1: 1 = load, 0 = store.
- `req_funct3` in 3: RV32I width/sign code.
- `req_addr` in 32: effective byte address.
- `req_wdata` in 32: rs2 value for stores.
- `req_rd` in 5: load destination register.
- `dmem_req` out 1: memory request, held until ack.
- `dmem_we` out 1: store request.
- `dmem_addr` out 32: `{addr[31:2],2'b00}`.
- `dmem_wstrb` out 4: byte-lane strobes (0000 on loads).
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: memory completes this cycle; `dmem_rdata` valid with it.
- `dmem_rdata` in 32: word read data.
- `rf_we` out 1: register-file write pulse.
- `rf_w_addr` out 5: destination register.
- `rf_w_data` out 32: aligned load result.
- `fault` out 1: one-cycle exception pulse.
- `fault_cause` out 2: 01 load misaligned, 10 store misaligned, 11 illegal funct3; valid with `fault`.
- `fault_addr` out 32: offending `req_addr`; valid with `fault`.

## Operation
- States: IDLE, ACCESS, WB, FAULT. Encoding 2 bits, defined in the shared include.
- **IDLE, on accept:** register all `req_*` fields, then classify the operation.
  - Illegal funct3 goes to FAULT. Loads: 011, 110, 111 are illegal. Stores: any value ≥ 011 is illegal.
  - Misaligned goes to FAULT. Halfword with `addr[0]=1`, or word with `addr[1:0]≠00`.
  - Otherwise go to ACCESS.
- **ACCESS:** `dmem_req` = 1; address, strobes and write data are stable.
  - Stays in ACCESS until `dmem_ack`.
  - On ack, a load captures `dmem_rdata` and goes to WB; a store goes to IDLE.
- **WB:** `rf_we` = (`rd`≠0); `rf_w_data` = extracted value. Always returns to IDLE.
- **FAULT:** `fault` = 1 with cause and address. Returns to IDLE. Never raises `dmem_req` or `rf_we`.
- **Store lanes:**
  - SB: `wdata = {4{rs2[7:0]}}`, `wstrb = 0001 << addr[1:0]`.
  - SH: `wdata = {2{rs2[15:0]}}`, `wstrb` = 0011 if `addr[1]`=0, else 1100.
  - SW: `wstrb` = 1111.
- **Load extract:**
  - Byte lane is `addr[1:0]`; halfword is selected by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `dmem_ack` outside ACCESS is ignored.
- `req_valid` while not ready is held by upstream; contents may change and are not sampled.

## Timing
- **Reset (async):** state IDLE; every output 0 except `req_ready` = 1. Registered request fields clear to 0.
- **Load with zero-wait ack:**
  - Accept at T.
  - `dmem_req` high at T+1; ack arrives at T+1.
  - `rf_we` pulse at T+2.
  - `req_ready` high at T+3.
- **Store with zero-wait ack:** accept at T, ack at T+1, `req_ready` high at T+2.
- **Wait states:** each cycle without ack adds one cycle; outputs are held constant throughout.
- **Fault:** accept at T, `fault` at T+1, `req_ready` at T+2.
- `rf_*` and `dmem_*` are all registered outputs; there is no combinational path from `req_*`.
- **Reset mid-ACCESS:** `dmem_req` drops immediately. The memory must tolerate an abandoned request; a late ack after reset is ignored.

## Structure
- Shared include `lsu_defs.vh`:
  - funct3 localparams (LB=000 … LHU=101, SB/SH/SW).
  - State encodings.
  - `fault_cause` codes.
- Sub-module `load_align`: purely combinational. Inputs are `rdata`, `addr[1:0]` and `funct3`; output is the 32-bit extended value.
- FSM, request registers and store-lane logic live in `lsu_wb`.

## Test plan
- **LB sign extension:** LB at addr 0x103, rd=5; `rdata` = 0x80FF_0000, ack after 2 wait cycles → `dmem_addr` = 0x100, then `rf_we` with addr 5, data 0xFFFF_FF80, one cycle after ack.
- **Store halfword:** SH at addr 0x206, rs2 = 0x1234_ABCD → `dmem_we` = 1, `wstrb` = 1100, `wdata` = 0xABCD_ABCD; `req_ready` returns the cycle after ack; no `rf_we`.
- **Misaligned load:** LW at 0x1002 → no `dmem_req`; `fault` = 1, cause 01, addr 0x1002 at T+1; `req_ready` at T+2.
- **Illegal funct3 and x0 load:**
  - Store with funct3 = 011 → `fault` with cause 11.
  - LBU to rd=0 with `rdata` 0xFF → no `rf_we`; ready returns normally.
- **Back-to-back with reset:**
  - Back-to-back LW at 0x0 and 0x4 with zero-wait ack → writes exactly 3 cycles apart.
  - `rst_n` asserted low mid-ACCESS → `dmem_req` = 0 immediately and `req_ready` = 1.
  - Ack arriving after reset release is ignored.
